spi_slave: RTL
==============

Name: spi_slave

Overview:
- SPI mode-0 slave (CPOL=0, CPHA=0), MSB first; the far end of the team's SPI master (spi_topmodule).
- Oversamples the external ss/sclk/mosi with the system clock. Receives one DATA_W-bit word per byte and shifts out a buffered transmit word on miso.
- Supports back-to-back bytes within one ss-low frame.
- Sits between the SPI pins and the local register/control logic, which uses a ready/load handshake to transmit and a valid strobe to receive.

Parameters:
- DATA_W, 8: word width in bits; also the bits per SPI byte.
- SYNC_STAGES, 2: synchroniser depth on ss, sclk and mosi; minimum 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ss  in  1  chip select from master, active low, asynchronous to clk.
- sclk  in  1  SPI clock from master, idles low, asynchronous to clk.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data; driven 0 whenever ss (synchronised) is high.
- tx_data  in  DATA_W  word to send next.
- tx_load  in  1  write strobe for tx_data; accepted only when tx_ready=1.
- tx_ready  out  1  transmit buffer empty.
- rx_data  out  DATA_W  last fully received word; held until the next word completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high while synchronised ss is low.

Behaviour:
- Reset values (async, active-high): miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, bit_cnt=0, shift registers=0, synchronisers=idle (ss=1, sclk=0, mosi=0). Reset mid-frame aborts silently.
- Sync: ss, sclk and mosi each pass through a SYNC_STAGES flop chain. Edges are detected against one further delay flop.
- Timing constraint: sclk high and low times must each be at least SYNC_STAGES+2 clk periods.
- FSM IDLE -> ACTIVE on the ss falling edge. ACTIVE -> IDLE on the ss rising edge.
- On ss falling: bit_cnt=0, tx_shift loaded (load rule below), miso=tx_shift MSB.
- On sclk rising in ACTIVE: rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}, and bit_cnt increments.
- When bit_cnt was DATA_W-1 on that rising edge:
  - rx_data <= assembled word and rx_valid=1 for exactly one cycle;
  - bit_cnt wraps to 0.
- Receive latency: rx_valid is high in the cycle after clk edge SYNC_STAGES+1, counted from the first clk edge that samples sclk high.
- On sclk falling in ACTIVE:
  - bit_cnt!=0: tx_shift shifts left by one;
  - bit_cnt==0 (byte boundary): tx_shift is reloaded.
  - In both cases miso=new tx_shift MSB.
- Load rule:
  - buffer full: take the buffer and set tx_ready=1;
  - buffer empty with tx_load in the same cycle: bypass tx_data straight into tx_shift, buffer stays empty;
  - buffer empty and no tx_load: load all zeros.
- tx_load with tx_ready=0 is ignored and the buffer is unchanged.
- tx_load with tx_ready=1 and no consume: buffer=tx_data, tx_ready=0 next cycle.
- ss rising mid-byte (bit_cnt!=0): partial word discarded, no rx_valid, bit_cnt=0, miso=0. The tx buffer is untouched.
- sclk edges while ss is high are ignored.
- rx overrun is not detected: a new word overwrites rx_data.

Optional Feature:
- Macro: SPI_SLAVE_FRAME_ERR_EN.
- Defined: adds output frame_err (1 bit, reset 0). It pulses for one cycle on an ss rising edge when bit_cnt!=0, and on an sclk rising edge when rx_valid would fire while the previous rx_valid fired fewer than 2 cycles earlier.
- Undefined: the port is absent and aborts are silent.

Decomposition:
- Package spi_pkg: DATA_W default, SPI mode constants (CPOL=0, CPHA=0), and the FSM state encoding (IDLE, ACTIVE).
- Sub-module spi_sync_edge: a SYNC_STAGES synchroniser plus rise/fall pulse outputs, instantiated three times (edges unused for mosi).

Test Plan:
1. Reset, tx_load 0xCA, ss low, master sends 0xAD with sclk = 8 clk periods -> master captures 0xCA; rx_data=0xAD; one rx_valid pulse; tx_ready=1 after the ss fall.
2. Two back-to-back bytes in one frame: buffer 0x5A, then load 0x3C once tx_ready rises; master sends 0x11, 0x22 -> miso carries 0x5A then 0x3C; two rx_valid pulses with 0x11, 0x22.
3. Empty buffer at the ss fall -> miso all zeros for the byte; rx still correct.
4. ss raised after 5 sclk pulses -> no rx_valid, rx_data unchanged, miso=0. With SPI_SLAVE_FRAME_ERR_EN, one frame_err pulse. The next full frame receives correctly.
5. tx_load in the same cycle as the byte-boundary consume with the buffer empty -> that word is shifted out immediately and tx_ready stays 1.
6. rst asserted mid-byte -> all outputs return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI slave.
package spi_pkg;

    localparam int DEF_DATA_W = 8;

    // SPI mode 0: clock idles low, data sampled on the leading (rising) edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall pulses
// detected against one extra delay flop behind the synchronised output.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{IDLE_VAL}};
            dly   <= IDLE_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            dly   <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~dly;
    assign fall = ~sync & dly;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled by clk, with a one-word tx buffer.
// Optional macro SPI_SLAVE_FRAME_ERR_EN adds the frame_err abort/overrun pulse.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int             CNT_W          = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(DATA_W - 1);
    localparam logic           SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

    logic ss_sync, ss_rise, ss_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic unused_mosi_edges;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .din(ss),
        .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_mosi_edges = &{1'b0, mosi_rise, mosi_fall, sclk_sync};

    spi_state_t        state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_buf;
    logic              buf_full;

    logic              frame_start, frame_end, sample, shift, word_done, consume;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] rx_word;

    // ss_rise takes priority so a stray sclk edge in the closing cycle is dropped.
    assign frame_start = (state == IDLE) && ss_fall;
    assign frame_end   = (state == ACTIVE) && ss_rise;
    assign sample      = (state == ACTIVE) && !ss_rise && (SAMPLE_ON_RISE ? sclk_rise : sclk_fall);
    assign shift       = (state == ACTIVE) && !ss_rise && (SAMPLE_ON_RISE ? sclk_fall : sclk_rise);
    assign word_done   = sample && (bit_cnt == LAST_BIT);
    assign consume     = frame_start || (shift && (bit_cnt == '0));
    assign rx_word     = {rx_shift[DATA_W-2:0], mosi_sync};

    // Buffered word first, then a same-cycle bypass, otherwise send zeros.
    assign load_word = buf_full ? tx_buf : (tx_load ? tx_data : '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_shift <= '0;
            tx_buf   <= '0;
            buf_full <= 1'b0;
        end else begin
            state    <= state_nxt;
            rx_valid <= word_done;

            if (frame_start || frame_end) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sample) begin
                rx_shift <= rx_word;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    rx_data <= rx_word;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end

            if (consume)
                tx_shift <= load_word;
            else if (shift)
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

            if (consume && buf_full) begin
                buf_full <= 1'b0;
            end else if (tx_load && !buf_full && !consume) begin
                tx_buf   <= tx_data;
                buf_full <= 1'b1;
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_err <= 1'b0;
        else
            frame_err <= (frame_end && (bit_cnt != '0)) || (word_done && rx_valid);
    end
`endif

    assign miso     = (state == ACTIVE) && !ss_sync && tx_shift[DATA_W-1];
    assign tx_ready = ~buf_full;
    assign busy     = ~ss_sync;

endmodule
